// File: rtl/or_gate_stimulus_checker.sv
// or_gate_stimulus_checker: sweeps a two-input OR cell through all input patterns,
// synchronises its output back and counts mismatches against in1|in2.
module or_gate_stimulus_checker #(
   parameter int SETTLE = 4,
   parameter int LOOPS  = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             in1,
   output logic             in2,
   input  logic             out1,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       last_fail_vec
);
   localparam int CW = $clog2(SETTLE);
   localparam int LW = LOOPS > 1 ? $clog2(LOOPS) : 1;

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       pat_q, pat_d;
   logic [LW-1:0]    loop_q, loop_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [1:0]       lfv_q, lfv_d;
   logic [1:0]       in_q, in_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [1:0]       sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         loop_q  <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         lfv_q   <= '0;
         in_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         loop_q  <= loop_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         lfv_q   <= lfv_d;
         in_q    <= in_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         sync_q  <= {sync_q[0], out1};
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      loop_d  = loop_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      lfv_d   = lfv_q;
      in_d    = in_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = APPLY;
               pat_d   = '0;
               loop_d  = '0;
               cnt_d   = '0;
               err_d   = '0;
               lfv_d   = '0;
               in_d    = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         APPLY: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(SETTLE - 1)) begin
               cnt_d   = '0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // the synchronised sample reflects out1 captured SETTLE-1 cycles after the change
            if (sync_q[1] != (in_q[0] | in_q[1])) begin
               err_d = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
               lfv_d = in_q;
            end
            if (pat_q != 2'd3) begin
               pat_d   = pat_q + 2'd1;
               in_d    = pat_q + 2'd1;
               state_d = APPLY;
            end else if (loop_q != LW'(LOOPS - 1)) begin
               loop_d  = loop_q + LW'(1);
               pat_d   = '0;
               in_d    = '0;
               state_d = APPLY;
            end else begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
               in_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in1           = in_q[0];
   assign in2           = in_q[1];
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_cnt       = err_q;
   assign last_fail_vec = lfv_q;
endmodule

// File: tb/tb_or_gate_stimulus_checker.sv
// tb_or_gate_stimulus_checker: three checker instances driving configurable OR-cell models,
// each compared every cycle against a sweep-level model of the run.
module tb_or_gate_stimulus_checker;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_v, start_v, busy_v, done_v, pass_v;
   logic [7:0] err_v [3];
   logic [1:0] lfv_v [3];
   int mode [3];
   int dly  [3];
   int checks = 0, errs = 0;

   // cell behaviour: 0 OR, 1 stuck-at-0, 2 NOR, 3 stuck-at-1
   function automatic logic cellf(input logic [1:0] v, input int m);
      return m == 0 ? |v : m == 1 ? 1'b0 : m == 2 ? ~|v : 1'b1;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int S   = g == 2 ? 3 : 4;
      localparam int L   = g == 0 ? 1 : g == 1 ? 2 : 4;
      localparam int W   = g == 2 ? 2 : 8;
      localparam int P   = S + 1;
      localparam int TOT = L * 4 * P;
      localparam int MX  = (1 << W) - 1;
      logic in1, in2, out1, busy, done, pass;
      logic [W-1:0] err;
      logic [1:0] lfv, q1, q2;
      int checks = 0, errs = 0;
      bit run = 0;
      int t = 0, rm = 0, rd = 0;

      always @(posedge clk) begin
         q1 <= {in2, in1};
         q2 <= q1;
      end
      assign out1 = cellf(dly[g] == 0 ? {in2, in1} : dly[g] == 1 ? q1 : q2, mode[g]);

      or_gate_stimulus_checker #(.SETTLE(S), .LOOPS(L), .ERR_W(W)) u_dut (
         .clk(clk), .rst(rst_v[g]), .start(start_v[g]), .in1(in1), .in2(in2), .out1(out1),
         .busy(busy), .done(done), .pass(pass), .err_cnt(err), .last_fail_vec(lfv)
      );
      assign busy_v[g] = busy;
      assign done_v[g] = done;
      assign pass_v[g] = pass;
      assign err_v[g]  = 8'(err);
      assign lfv_v[g]  = lfv;

      // pattern j is sampled fresh when the cell delay fits inside SETTLE-2 cycles, else stale
      function automatic bit mis(input int j, input int m, input int d);
         int c  = j % 4;
         int pv = j == 0 ? 0 : (j - 1) % 4;
         int s  = d <= S - 2 ? c : pv;
         return cellf(2'(s), m) != (c != 0);
      endfunction

      always @(posedge clk) begin
         if (rst_v[g]) begin
            run <= 0;
            t   <= 0;
         end else if ((!run || t >= TOT) && start_v[g]) begin
            run <= 1;
            t   <= 0;
            rm  <= mode[g];
            rd  <= dly[g];
         end else if (run && t < TOT) t <= t + 1;
      end

      always @(negedge clk) begin
         logic [14:0] act, exp;
         logic [1:0] ein;
         logic eb, ed, ep;
         int ec, el, n;
         ein = 0; eb = 0; ed = 0; ec = 0; el = 0;
         if (run) begin
            n = t / P;
            if (n > 4 * L) n = 4 * L;
            for (int j = 0; j < n; j++) if (mis(j, rm, rd)) begin ec++; el = j % 4; end
            if (ec > MX) ec = MX;
            eb  = t < TOT;
            ed  = !eb;
            ein = eb ? 2'((t / P) % 4) : 2'd0;
         end
         ep  = ed && ec == 0;
         act = {busy, done, pass, in2, in1, 8'(err), lfv};
         exp = {eb, ed, ep, ein, 8'(ec), 2'(el)};
         checks++;
         if (act !== exp) begin
            errs++;
            $display("FAIL cycle inst%0d t=%0d: got busy=%b done=%b pass=%b in=%b err=%0d lfv=%b, expected busy=%b done=%b pass=%b in=%b err=%0d lfv=%b",
                     g, t, act[14], act[13], act[12], act[11:10], act[9:2], act[1:0],
                     exp[14], exp[13], exp[12], exp[11:10], exp[9:2], exp[1:0]);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run(input int g, input int m, input int d, output int lat);
      @(posedge clk); #1;
      mode[g] = m;
      dly[g]  = d;
      start_v[g] = 1'b1;
      @(posedge clk); #1;
      start_v[g] = 1'b0;
      lat = 0;
      while (!done_v[g] && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!done_v[g]) chk("done_timeout", 0, 1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   int lat;
   initial begin
      rst_v = 3'b111;
      start_v = 3'b000;
      for (int i = 0; i < 3; i++) begin mode[i] = 0; dly[i] = 0; end
      repeat (3) @(posedge clk);
      #1 rst_v = 3'b000;
      @(negedge clk);
      chk("reset_busy", int'(busy_v), 0);
      chk("reset_done", int'(done_v), 0);
      chk("reset_err0", int'(err_v[0]), 0);

      run(0, 0, 0, lat);
      chk("or_latency", lat, 20);
      chk("or_pass", int'(pass_v[0]), 1);
      chk("or_err", int'(err_v[0]), 0);
      chk("or_lfv", int'(lfv_v[0]), 0);

      run(0, 1, 0, lat);
      chk("sa0_err", int'(err_v[0]), 3);
      chk("sa0_lfv", int'(lfv_v[0]), 3);
      chk("sa0_pass", int'(pass_v[0]), 0);

      run(0, 2, 0, lat);
      chk("nor_err", int'(err_v[0]), 4);
      chk("nor_lfv", int'(lfv_v[0]), 3);

      run(1, 3, 0, lat);
      chk("sa1_latency", lat, 40);
      chk("sa1_err", int'(err_v[1]), 2);
      chk("sa1_lfv", int'(lfv_v[1]), 0);

      run(2, 2, 0, lat);
      chk("sat_err", int'(err_v[2]), 3);
      chk("sat_pass", int'(pass_v[2]), 0);

      run(2, 0, 1, lat);
      chk("dly1_pass", int'(pass_v[2]), 1);
      run(2, 0, 2, lat);
      chk("dly2_err", int'(err_v[2]), 3);
      chk("dly2_lfv", int'(lfv_v[2]), 1);

      // start pulse during pattern 2 must not restart the run
      mode[0] = 1;
      @(posedge clk); #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      repeat (11) @(posedge clk);
      #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      lat = 0;
      while (!done_v[0] && lat < 1000) begin @(posedge clk); #1; lat++; end
      chk("ignore_lat", lat, 8);
      chk("ignore_err", int'(err_v[0]), 3);

      // reset during pattern 2
      repeat (3) @(posedge clk);
      #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      repeat (11) @(posedge clk);
      #1 rst_v[0] = 1'b1;
      @(posedge clk); #1 rst_v[0] = 1'b0;
      @(negedge clk);
      chk("midrst_busy", int'(busy_v[0]), 0);
      chk("midrst_done", int'(done_v[0]), 0);
      chk("midrst_err", int'(err_v[0]), 0);

      // reset and start together: reset wins
      @(posedge clk); #1 begin rst_v[0] = 1'b1; start_v[0] = 1'b1; end
      @(posedge clk); #1 begin rst_v[0] = 1'b0; start_v[0] = 1'b0; end
      @(negedge clk);
      chk("rst_start_busy", int'(busy_v[0]), 0);

      run(0, 0, 0, lat);
      chk("fresh_latency", lat, 20);
      chk("fresh_pass", int'(pass_v[0]), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks + gi[0].checks + gi[1].checks + gi[2].checks,
               errs + gi[0].errs + gi[1].errs + gi[2].errs);
      $finish;
   end
endmodule
